// File: rtl/panda_div_multi_if.sv
// Pulse bus bundle for the multi-channel divider.
// Master drives inputs/enables; slave returns divided outputs.
interface panda_div_multi_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] inp_i;
  logic [NCH-1:0] enable_i;
  logic [NCH-1:0] outd_o;
  logic [NCH-1:0] outn_o;

  modport master (
    output inp_i,
    output enable_i,
    input  outd_o,
    input  outn_o
  );

  modport slave (
    input  inp_i,
    input  enable_i,
    output outd_o,
    output outn_o
  );
endinterface

// File: rtl/panda_div_multi.sv
// Multi-channel PandA pulse divider: every DIVISOR-th rising edge
// goes to outd_o, the rest to outn_o, in follow or single-pulse mode.
module panda_div_multi #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  panda_div_multi_if.slave     bus,
  input  logic                 FIRST_PULSE,
  input  logic [WIDTH-1:0]     DIVISOR,
  input  logic                 OUT_MODE,
  input  logic                 FORCE_RST,
  output logic [NCH*WIDTH-1:0] COUNT
);

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_D    = 2'd1;
  localparam logic [1:0] R_N    = 2'd2;

  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] div_max;
  logic [WIDTH-1:0] preset;

  logic [NCH-1:0] inp_dly_q;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] srst;

  logic [NCH-1:0][WIDTH-1:0] cnt_q;
  logic [NCH-1:0][WIDTH-1:0] cnt_d;
  logic [NCH-1:0][1:0]       route_q;
  logic [NCH-1:0][1:0]       route_d;
  logic [NCH-1:0]            outd_q;
  logic [NCH-1:0]            outd_d;
  logic [NCH-1:0]            outn_q;
  logic [NCH-1:0]            outn_d;

  always_comb begin
    div_eff = (DIVISOR == '0) ? WIDTH'(1) : DIVISOR;
    div_max = div_eff - WIDTH'(1);
    preset  = FIRST_PULSE ? div_max : '0;
  end

  assign rise = bus.inp_i & ~inp_dly_q;
  assign srst = {NCH{FORCE_RST}} | ~bus.enable_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inp_dly_q <= '0;
      cnt_q     <= '0;
      route_q   <= '0;
      outd_q    <= '0;
      outn_q    <= '0;
    end else begin
      inp_dly_q <= bus.inp_i;
      cnt_q     <= cnt_d;
      route_q   <= route_d;
      outd_q    <= outd_d;
      outn_q    <= outn_d;
    end
  end

  // Soft reset outranks a coincident edge, which is then dropped.
  always_comb begin
    cnt_d   = cnt_q;
    route_d = route_q;
    for (int k = 0; k < NCH; k++) begin
      if (srst[k]) begin
        cnt_d[k]   = preset;
        route_d[k] = R_NONE;
      end else if (rise[k]) begin
        if (cnt_q[k] >= div_max) begin
          route_d[k] = R_D;
          cnt_d[k]   = '0;
        end else begin
          route_d[k] = R_N;
          cnt_d[k]   = cnt_q[k] + WIDTH'(1);
        end
      end else if (OUT_MODE || !bus.inp_i[k]) begin
        route_d[k] = R_NONE;
      end
    end
  end

  always_comb begin
    outd_d = '0;
    outn_d = '0;
    for (int k = 0; k < NCH; k++) begin
      logic act;
      act       = OUT_MODE ? rise[k] : bus.inp_i[k];
      outd_d[k] = act && (route_d[k] == R_D);
      outn_d[k] = act && (route_d[k] == R_N);
    end
  end

  assign bus.outd_o = outd_q;
  assign bus.outn_o = outn_q;
  assign COUNT      = cnt_q;

endmodule

// File: tb/tb_panda_div_multi.sv
// Bench for panda_div_multi: per-cycle model compare plus
// directed pulse trains with literal pattern/count expectations.
module tb_panda_div_multi;
  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int CW  = NCH * W;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          first = 1'b0;
  logic          mode = 1'b0;
  logic          frc = 1'b0;
  logic [W-1:0]  divisor = 32'd3;
  logic [CW-1:0] count;

  panda_div_multi_if #(.NCH(NCH)) bus ();

  panda_div_multi #(.NCH(NCH), .WIDTH(W)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .bus         (bus.slave),
    .FIRST_PULSE (first),
    .DIVISOR     (divisor),
    .OUT_MODE    (mode),
    .FORCE_RST   (frc),
    .COUNT       (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: edges counted since soft reset, owner of the live pulse.
  int           m_cnt [NCH];
  int           m_own [NCH];
  logic [NCH-1:0] m_prev;
  logic [NCH-1:0] m_d;
  logic [NCH-1:0] m_n;
  int           m_div;
  logic         m_rise;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_prev = '0;
      m_d    = '0;
      m_n    = '0;
      for (int k = 0; k < NCH; k++) begin
        m_cnt[k] = 0;
        m_own[k] = 0;
      end
    end else begin
      m_div = (divisor == 0) ? 1 : int'(divisor);
      for (int k = 0; k < NCH; k++) begin
        m_rise = bus.inp_i[k] && !m_prev[k];
        if (frc || !bus.enable_i[k]) begin
          m_cnt[k] = first ? m_div - 1 : 0;
          m_own[k] = 0;
          m_d[k]   = 1'b0;
          m_n[k]   = 1'b0;
        end else if (m_rise) begin
          if (m_cnt[k] + 1 >= m_div) begin
            m_own[k] = 1;
            m_cnt[k] = 0;
          end else begin
            m_own[k] = 2;
            m_cnt[k] = m_cnt[k] + 1;
          end
          m_d[k] = (m_own[k] == 1);
          m_n[k] = (m_own[k] == 2);
        end else if (mode) begin
          m_own[k] = 0;
          m_d[k]   = 1'b0;
          m_n[k]   = 1'b0;
        end else begin
          if (!bus.inp_i[k]) m_own[k] = 0;
          m_d[k] = (m_own[k] == 1);
          m_n[k] = (m_own[k] == 2);
        end
        m_prev[k] = bus.inp_i[k];
      end
    end
  end

  // Channel-0 event recorder, cleared by the stimulus between tests.
  string pat0 = "";
  string cnt0 = "";
  int    hi0  = 0;
  logic  ld0  = 1'b0;
  logic  ln0  = 1'b0;
  logic [CW-1:0] m_flat;

  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) m_flat[k*W +: W] = W'(m_cnt[k]);
    checks++;
    if (bus.outd_o !== m_d || bus.outn_o !== m_n || count !== m_flat) begin
      errors++;
      $display("FAIL model t=%0t outd=%b/%b outn=%b/%b count=%h req %h",
               $time, bus.outd_o, m_d, bus.outn_o, m_n, count, m_flat);
    end
    if (bus.outd_o[0] && !ld0) begin
      pat0 = {pat0, "D"};
      cnt0 = {cnt0, $sformatf("%0d", count[W-1:0])};
    end
    if (bus.outn_o[0] && !ln0) begin
      pat0 = {pat0, "N"};
      cnt0 = {cnt0, $sformatf("%0d", count[W-1:0])};
    end
    if (bus.outd_o[0] || bus.outn_o[0]) hi0++;
    ld0 = bus.outd_o[0];
    ln0 = bus.outn_o[0];
  end

  task automatic chk(input string nm, input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h need %0h", nm, act, exp);
    end
  endtask

  task automatic chks(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got '%s' need '%s'", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulses(input int ch, input int hi, input int lo, input int n);
    repeat (n) begin
      bus.inp_i[ch] = 1'b1;
      step(hi);
      bus.inp_i[ch] = 1'b0;
      step(lo);
    end
  endtask

  task automatic clr();
    pat0 = "";
    cnt0 = "";
    hi0  = 0;
  endtask

  task automatic force_rst();
    frc = 1'b1;
    step(1);
    frc = 1'b0;
  endtask

  initial begin
    bus.inp_i    = '0;
    bus.enable_i = 4'b0001;
    step(2);
    chk("reset_outd", CW'(bus.outd_o), '0);
    chk("reset_outn", CW'(bus.outn_o), '0);
    chk("reset_count", count, '0);
    rstn = 1'b1;
    step(1);

    // Follow mode, divide by 3
    clr();
    pulses(0, 2, 2, 6);
    step(2);
    chks("t1_pattern", pat0, "NNDNND");
    chks("t1_counts", cnt0, "120120");
    chk("t1_high_cycles", CW'(hi0), CW'(12));

    // FIRST_PULSE preset through enable
    bus.enable_i = 4'b0000;
    first = 1'b1;
    step(2);
    chk("t2_preset", CW'(count[W-1:0]), CW'(2));
    bus.enable_i = 4'b0001;
    clr();
    pulses(0, 2, 2, 3);
    step(2);
    chks("t2_pattern", pat0, "DNN");
    chks("t2_counts", cnt0, "012");

    // Pulse mode, divide by 2
    mode = 1'b1;
    divisor = 32'd2;
    first = 1'b0;
    force_rst();
    clr();
    pulses(0, 5, 2, 4);
    step(2);
    chks("t3_pattern", pat0, "NDND");
    chk("t3_high_cycles", CW'(hi0), CW'(4));

    // DIVISOR 0 and 1
    mode = 1'b0;
    divisor = 32'd0;
    force_rst();
    clr();
    pulses(0, 2, 2, 3);
    step(2);
    chks("t4_div0_pattern", pat0, "DDD");
    chks("t4_div0_counts", cnt0, "000");
    divisor = 32'd1;
    force_rst();
    clr();
    pulses(0, 2, 2, 3);
    step(2);
    chks("t4_div1_pattern", pat0, "DDD");
    chks("t4_div1_counts", cnt0, "000");

    // DIVISOR lowered below count
    divisor = 32'd5;
    force_rst();
    clr();
    pulses(0, 2, 2, 3);
    chks("t5_pre_pattern", pat0, "NNN");
    chk("t5_pre_count", CW'(count[W-1:0]), CW'(3));
    divisor = 32'd2;
    clr();
    pulses(0, 2, 2, 1);
    step(1);
    chks("t5_wrap_pattern", pat0, "D");
    chk("t5_wrap_count", CW'(count[W-1:0]), CW'(0));

    // FORCE_RST during an active follow pulse, preset 1
    first = 1'b1;
    bus.inp_i[0] = 1'b1;
    step(1);
    chk("t5_live_outn", CW'(bus.outn_o[0]), CW'(1));
    force_rst();
    chk("t5_frc_outs", CW'({bus.outd_o[0], bus.outn_o[0]}), CW'(0));
    chk("t5_frc_count", CW'(count[W-1:0]), CW'(1));
    step(1);
    chk("t5_frc_hold", CW'({bus.outd_o[0], bus.outn_o[0]}), CW'(0));
    bus.inp_i[0] = 1'b0;
    step(1);
    bus.inp_i[0] = 1'b1;
    force_rst();
    chk("t5_coinc_count", CW'(count[W-1:0]), CW'(1));
    step(1);
    chk("t5_coinc_outs", CW'({bus.outd_o[0], bus.outn_o[0]}), CW'(0));
    bus.inp_i[0] = 1'b0;
    step(2);

    // Four channels, enable drop and async reset mid-run
    first = 1'b0;
    divisor = 32'd3;
    bus.enable_i = 4'b1111;
    force_rst();
    for (int c = 0; c < 30; c++) begin
      bus.inp_i[0] = (c % 2) == 1;
      bus.inp_i[1] = (c % 4) < 2;
      bus.inp_i[2] = (c % 6) < 3;
      bus.inp_i[3] = (c % 5) == 1 || (c % 5) == 2;
      if (c == 13) bus.enable_i[2] = 1'b0;
      step(1);
      if (c == 13)
        chk("t6_ch2_off", CW'({bus.outd_o[2], bus.outn_o[2]}), CW'(0));
    end
    bus.inp_i = 4'b1111;
    rstn = 1'b0;
    #1;
    chk("t6_arst_outd", CW'(bus.outd_o), '0);
    chk("t6_arst_outn", CW'(bus.outn_o), '0);
    chk("t6_arst_count", count, '0);
    step(2);
    rstn = 1'b1;
    bus.inp_i = '0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
